lfsr_checker: RTL and testbench

LFSR_CHECKER -- requirements
Module: lfsr_checker

---
 rtl/lab1_pkg.sv | 21 ++
 rtl/lfsr16_pred.sv | 12 +
 rtl/lfsr_checker.sv | 170 +++++++++++++++++
 tb/tb_lfsr_checker.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/lab1_pkg.sv
// Shared LFSR definitions: the 16-bit Fibonacci polynomial taps and the
// checker state encoding, shared by the checker and any stream generator.
package lab1_pkg;

  localparam int LFSR_W = 16;

  localparam int TAP_A = 0;
  localparam int TAP_B = 2;
  localparam int TAP_C = 3;
  localparam int TAP_D = 5;

  localparam logic [LFSR_W-1:0] TAP_MASK =
    LFSR_W'((1 << TAP_A) | (1 << TAP_B) | (1 << TAP_C) | (1 << TAP_D));

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCK   = 2'd2
  } state_e;

endpackage

// File: rtl/lfsr16_pred.sv
// Combinational next-bit predictor for the 16-bit Fibonacci LFSR.
// i_h[0] is the oldest bit; o_p is the bit the sequence must produce next.
module lfsr16_pred
  import lab1_pkg::*;
(
  input  logic [LFSR_W-1:0] i_h,
  output logic              o_p
);

  assign o_p = ^(i_h & TAP_MASK);

endmodule

// File: rtl/lfsr_checker.sv
// PRBS checker for the 16-bit Fibonacci LFSR stream: hunt, verify, lock,
// error counting and loss-of-lock. Define LFSR_CHK_NIBBLE_EN to also check nibble overlap.
module lfsr_checker
  import lab1_pkg::*;
#(
  parameter int LOSS_WIN = 64,
  parameter int LOSS_THR = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [3:0]  i_data,
  input  logic        i_clear,
  output logic        o_locked,
  output logic        o_err,
  output logic [15:0] o_err_count
);

  localparam int FILL_W = $clog2(LFSR_W + 1);
  localparam int WIN_W  = (LOSS_WIN > 1) ? $clog2(LOSS_WIN) : 1;
  localparam int THR_W  = $clog2(LOSS_THR + 1);

  state_e              state_q, state_d;
  logic [LFSR_W-1:0]   h_q, h_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [FILL_W-1:0]   vcnt_q, vcnt_d;
  logic [WIN_W-1:0]    win_q, win_d;
  logic [THR_W-1:0]    wmis_q, wmis_d;
  logic                locked_q, locked_d;
  logic                err_q, err_d;
  logic [15:0]         cnt_q, cnt_d;

  logic                p;
  logic                stream_bit;
  logic                bit_mis;
  logic                nib_mis;
  logic                lock_mis;
  logic [THR_W-1:0]    wmis_inc;
  logic [LFSR_W-1:0]   h_shift_rx;

  lfsr16_pred u_pred (
    .i_h (h_q),
    .o_p (p)
  );

  assign stream_bit = i_data[0];
  assign bit_mis    = stream_bit ^ p;
  assign h_shift_rx = {stream_bit, h_q[LFSR_W-1:1]};

`ifdef LFSR_CHK_NIBBLE_EN
  // Consecutive nibbles overlap by three bits of the same stream.
  logic [2:0] prev_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_q <= '0;
    end else if (i_valid) begin
      prev_q <= i_data[3:1];
    end
  end

  assign nib_mis = (i_data[2:0] != prev_q);
`else
  logic unused_nibble;
  assign unused_nibble = ^i_data[3:1];
  assign nib_mis       = 1'b0;
`endif

  assign lock_mis = i_valid && (state_q == S_LOCK) && (bit_mis || nib_mis);
  assign wmis_inc = wmis_q + THR_W'(lock_mis);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_HUNT;
      h_q      <= '0;
      fill_q   <= '0;
      vcnt_q   <= '0;
      win_q    <= '0;
      wmis_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      fill_q   <= fill_d;
      vcnt_q   <= vcnt_d;
      win_q    <= win_d;
      wmis_q   <= wmis_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and history/counter update
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    fill_d  = fill_q;
    vcnt_d  = vcnt_q;
    win_d   = win_q;
    wmis_d  = wmis_q;
    if (i_valid) begin
      unique case (state_q)
        S_HUNT: begin
          h_d    = h_shift_rx;
          fill_d = fill_q + FILL_W'(1);
          if (fill_q == FILL_W'(LFSR_W - 1)) begin
            state_d = S_VERIFY;
            vcnt_d  = '0;
          end
        end
        S_VERIFY: begin
          // An all-zero history predicts zeros forever, so it can never qualify.
          if ((h_q == '0) || bit_mis) begin
            state_d = S_HUNT;
            fill_d  = '0;
          end else begin
            h_d    = h_shift_rx;
            vcnt_d = vcnt_q + FILL_W'(1);
            if (vcnt_q == FILL_W'(LFSR_W - 1)) begin
              state_d = S_LOCK;
              win_d   = '0;
              wmis_d  = '0;
            end
          end
        end
        S_LOCK: begin
          // Feed back the prediction so a corrupted bit cannot poison the history.
          h_d = {p, h_q[LFSR_W-1:1]};
          if (wmis_inc >= THR_W'(LOSS_THR)) begin
            state_d = S_HUNT;
            fill_d  = '0;
            win_d   = '0;
            wmis_d  = '0;
          end else if (win_q == WIN_W'(LOSS_WIN - 1)) begin
            win_d  = '0;
            wmis_d = '0;
          end else begin
            win_d  = win_q + WIN_W'(1);
            wmis_d = wmis_inc;
          end
        end
        default: begin
          state_d = S_HUNT;
          fill_d  = '0;
        end
      endcase
    end
  end

  // Output next values
  always_comb begin
    locked_d = (state_q == S_LOCK);
    err_d    = lock_mis;
    cnt_d    = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (lock_mis && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  assign o_locked    = locked_q;
  assign o_err       = err_q;
  assign o_err_count = cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: directed lock/error/loss/clear/reset
// scenarios plus randomized traffic against a queue-based reference model.
module tb_lfsr_checker;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [3:0]  i_data = 4'h0;
  logic        i_clear = 1'b0;
  logic        o_locked;
  logic        o_err;
  logic [15:0] o_err_count;

  int n_chk  = 0;
  int n_fail = 0;

  lfsr_checker #(
    .LOSS_WIN (64),
    .LOSS_THR (8)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .i_clear     (i_clear),
    .o_locked    (o_locked),
    .o_err       (o_err),
    .o_err_count (o_err_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Stream generator: gq always holds the next 16 sequence bits, gq[0] first.
  bit gq[$];

  task automatic gen_seed(input logic [15:0] s);
    gq.delete();
    for (int i = 0; i < 16; i++) gq.push_back(s[i]);
  endtask

  task automatic gen_next(output logic [3:0] n);
    gq.push_back(gq[0] ^ gq[2] ^ gq[3] ^ gq[5]);
    n = {gq[3], gq[2], gq[1], gq[0]};
    void'(gq.pop_front());
  endtask

  // Reference model: mode 0 hunting, 1 verifying, 2 locked.
  int m_mode, m_fill, m_vcnt, m_win, m_wmis;
  bit mh[$];
  bit e_locked, e_err;
  int e_cnt;

  task automatic model_reset();
    m_mode = 0; m_fill = 0; m_vcnt = 0; m_win = 0; m_wmis = 0;
    mh.delete();
    for (int i = 0; i < 16; i++) mh.push_back(1'b0);
    e_locked = 1'b0; e_err = 1'b0; e_cnt = 0;
  endtask

  task automatic model_shift(input bit b);
    mh.push_back(b);
    void'(mh.pop_front());
  endtask

  task automatic model_edge(input bit v, input logic [3:0] d, input bit c);
    bit pred;
    bit mis;
    int ones;
    pred = mh[0] ^ mh[2] ^ mh[3] ^ mh[5];
    mis  = v && (m_mode == 2) && (d[0] != pred);
    ones = 0;
    foreach (mh[i]) ones += int'(mh[i]);
    e_locked = (m_mode == 2);
    e_err    = mis;
    if (c) e_cnt = 0;
    else if (mis && e_cnt < 65535) e_cnt++;
    if (v) begin
      if (m_mode == 0) begin
        model_shift(d[0]);
        m_fill++;
        if (m_fill == 16) begin m_mode = 1; m_vcnt = 0; end
      end else if (m_mode == 1) begin
        if (ones == 0 || d[0] != pred) begin
          m_mode = 0; m_fill = 0;
        end else begin
          model_shift(d[0]);
          m_vcnt++;
          if (m_vcnt == 16) begin m_mode = 2; m_win = 0; m_wmis = 0; end
        end
      end else begin
        model_shift(pred);
        m_wmis += int'(mis);
        m_win++;
        if (m_wmis >= 8) begin
          m_mode = 0; m_fill = 0;
        end else if (m_win == 64) begin
          m_win = 0; m_wmis = 0;
        end
      end
    end
  endtask

  task automatic step(input bit v, input logic [3:0] d, input bit c);
    i_valid = v; i_data = d; i_clear = c;
    @(posedge i_clk);
    model_edge(v, d, c);
    #1;
    chk("locked", 32'(o_locked), 32'(e_locked));
    chk("err", 32'(o_err), 32'(e_err));
    chk("count", 32'(o_err_count), 32'(e_cnt));
  endtask

  task automatic send(input bit err, input bit clr);
    logic [3:0] n;
    gen_next(n);
    if (err) n[0] = ~n[0];
    step(1'b1, n, clr);
  endtask

  task automatic idle(input bit clr);
    step(1'b0, 4'($urandom), clr);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0; i_valid = 1'b0; i_clear = 1'b0;
    #1;
    model_reset();
    chk("rst_locked", 32'(o_locked), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_count", 32'(o_err_count), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required self-termination");
    $fatal(1, "watchdog");
  end

  initial begin
    bit c;
    int pe;
    model_reset();
    do_reset();

    // Clean stream from seed ACE1: lock one cycle after the 32nd valid bit.
    gen_seed(16'hACE1);
    for (int i = 0; i < 32; i++) send(1'b0, 1'b0);
    chk("s_clean_not_yet", 32'(o_locked), 32'd0);
    send(1'b0, 1'b0);
    chk("s_clean_locked", 32'(o_locked), 32'd1);
    for (int i = 33; i < 100; i++) send(1'b0, 1'b0);
    chk("s_clean_count", 32'(o_err_count), 32'd0);

    // Single inverted bit 40.
    do_reset();
    for (int i = 0; i < 39; i++) send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    chk("s_single_err", 32'(o_err), 32'd1);
    chk("s_single_count", 32'(o_err_count), 32'd1);
    chk("s_single_locked", 32'(o_locked), 32'd1);
    for (int i = 0; i < 23; i++) begin
      send(1'b0, 1'b0);
      chk("s_single_quiet", 32'(o_err), 32'd0);
    end
    chk("s_single_count2", 32'(o_err_count), 32'd1);
    chk("s_single_locked2", 32'(o_locked), 32'd1);

    // Eight errors within one window force relock.
    do_reset();
    for (int i = 0; i < 33; i++) send(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 1'b0);
      if (i < 7) send(1'b0, 1'b0);
    end
    chk("s_loss_count", 32'(o_err_count), 32'd8);
    chk("s_loss_still", 32'(o_locked), 32'd1);
    send(1'b0, 1'b0);
    chk("s_loss_dropped", 32'(o_locked), 32'd0);
    for (int i = 1; i < 32; i++) send(1'b0, 1'b0);
    chk("s_relock_not_yet", 32'(o_locked), 32'd0);
    send(1'b0, 1'b0);
    chk("s_relock", 32'(o_locked), 32'd1);
    chk("s_relock_count", 32'(o_err_count), 32'd8);

    // All-zero stream never locks.
    do_reset();
    for (int i = 0; i < 50; i++) begin
      step(1'b1, 4'h0, 1'b0);
      chk("s_zero_unlocked", 32'(o_locked), 32'd0);
    end

    // Clear coincident with a mismatch.
    do_reset();
    for (int i = 0; i < 33; i++) send(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 1'b0);
      send(1'b0, 1'b0);
    end
    chk("s_clear_pre", 32'(o_err_count), 32'd5);
    send(1'b1, 1'b1);
    chk("s_clear_count", 32'(o_err_count), 32'd0);
    chk("s_clear_err", 32'(o_err), 32'd1);

    // Reset while locked, then relock from fresh bits.
    for (int i = 0; i < 4; i++) send(1'b0, 1'b0);
    chk("s_rst_pre_locked", 32'(o_locked), 32'd1);
    do_reset();
    for (int i = 0; i < 32; i++) send(1'b0, 1'b0);
    chk("s_rst_not_yet", 32'(o_locked), 32'd0);
    send(1'b0, 1'b0);
    chk("s_rst_relock", 32'(o_locked), 32'd1);

    // Randomized traffic: gaps, bit errors, clears; denser errors later.
    for (int i = 0; i < 3000; i++) begin
      c  = ($urandom_range(0, 49) == 0);
      pe = (i < 1500) ? 4 : 20;
      if ($urandom_range(0, 99) < 80) send($urandom_range(0, 99) < pe, c);
      else idle(c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
